// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue between the execute stage and the register-file write port.
// Drains one result per cycle and forwards pending results to the decode read operands.
module regfile_writeback_queue #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_res_valid,
    output logic                       o_res_ready,
    input  logic [ADDR_W-1:0]          i_res_dest,
    input  logic [WIDTH-1:0]           i_res_data,
    input  logic                       i_wb_hold,
    output logic                       o_wr_en,
    output logic [ADDR_W-1:0]          o_wr_addr,
    output logic [WIDTH-1:0]           o_wr_data,
    input  logic [ADDR_W-1:0]          i_rd_addr1,
    input  logic [ADDR_W-1:0]          i_rd_addr2,
    input  logic [WIDTH-1:0]           i_rf_data1,
    input  logic [WIDTH-1:0]           i_rf_data2,
    output logic [WIDTH-1:0]           o_fwd_data1,
    output logic [WIDTH-1:0]           o_fwd_data2,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_dest [DEPTH];
    logic [WIDTH-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A handshake to r0 completes but is dropped instead of occupying a slot.
    assign w_accept = i_res_valid && o_res_ready;
    assign w_push   = w_accept && (i_res_dest != '0);
    assign w_pop    = o_wr_en;

    assign o_res_ready = !rst && !w_full;
    assign o_wr_en     = !w_empty && !i_wb_hold && !rst;
    assign o_wr_addr   = r_dest[r_head];
    assign o_wr_data   = r_data[r_head];
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is deliberately not reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dest[r_tail] <= i_res_dest;
            r_data[r_tail] <= i_res_data;
        end
    end

    // Walk from oldest to youngest so the last match (youngest) wins.
    function automatic logic [WIDTH-1:0] forward(input logic [ADDR_W-1:0] addr,
                                                 input logic [WIDTH-1:0]  rf_data);
        logic [WIDTH-1:0] result;
        logic [PTR_W-1:0] idx;
        result = rf_data;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PTR_W'(i);
            if (r_valid[idx] && (r_dest[idx] == addr)) begin
                result = r_data[idx];
            end
        end
        if (addr == '0) begin
            result = '0;
        end
        return result;
    endfunction

    always_comb begin
        o_fwd_data1 = forward(i_rd_addr1, i_rf_data1);
        o_fwd_data2 = forward(i_rd_addr2, i_rf_data2);
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed self-checking bench for regfile_writeback_queue: handshake, drain order,
// forwarding, r0 handling, steady-state wrap and mid-operation reset.
module tb_regfile_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_dest;
    logic [31:0] res_data;
    logic        wb_hold;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    regfile_writeback_queue #(.WIDTH(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_res_valid (res_valid),
        .o_res_ready (res_ready),
        .i_res_dest  (res_dest),
        .i_res_data  (res_data),
        .i_wb_hold   (wb_hold),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .i_rd_addr1  (rd_addr1),
        .i_rd_addr2  (rd_addr2),
        .i_rf_data1  (rf_data1),
        .i_rf_data2  (rf_data2),
        .o_fwd_data1 (fwd_data1),
        .o_fwd_data2 (fwd_data2),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] dest,
                                 input logic [31:0] data, input logic hold);
        res_valid = valid;
        res_dest  = dest;
        res_data  = data;
        wb_hold   = hold;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        rf_data1 = 32'h0; rf_data2 = 32'h0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);

        // Reset behaviour
        tick();
        tick();
        checkOutput("rst_ready", {31'b0, res_ready}, 32'd0);
        checkOutput("rst_wren", {31'b0, wr_en}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_count", {29'b0, count}, 32'd0);
        checkOutput("post_rst_empty", {31'b0, empty}, 32'd1);
        checkOutput("post_rst_full", {31'b0, full}, 32'd0);
        checkOutput("post_rst_ready", {31'b0, res_ready}, 32'd1);

        // Single result, one-cycle latency to the write port
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        checkOutput("t1_wren_before", {31'b0, wr_en}, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t1_wren", {31'b0, wr_en}, 32'd1);
        checkOutput("t1_addr", {27'b0, wr_addr}, 32'd5);
        checkOutput("t1_data", wr_data, 32'hDEADBEEF);
        checkOutput("t1_count", {29'b0, count}, 32'd1);
        tick();
        checkOutput("t1_count_after", {29'b0, count}, 32'd0);
        checkOutput("t1_empty_after", {31'b0, empty}, 32'd1);
        checkOutput("t1_wren_after", {31'b0, wr_en}, 32'd0);

        // Fill under hold, stall a fifth, then drain in order
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 5'(k), 32'(k), 1'b1);
            tick();
        end
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1);
        checkOutput("t2_full", {31'b0, full}, 32'd1);
        checkOutput("t2_ready", {31'b0, res_ready}, 32'd0);
        checkOutput("t2_count", {29'b0, count}, 32'd4);
        checkOutput("t2_hold_wren", {31'b0, wr_en}, 32'd0);
        tick();
        checkOutput("t2_stalled_count", {29'b0, count}, 32'd4);
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0);
        checkOutput("t2_d1_wren", {31'b0, wr_en}, 32'd1);
        checkOutput("t2_d1_addr", {27'b0, wr_addr}, 32'd1);
        checkOutput("t2_d1_ready", {31'b0, res_ready}, 32'd0);
        tick();
        checkOutput("t2_d2_addr", {27'b0, wr_addr}, 32'd2);
        checkOutput("t2_d2_ready", {31'b0, res_ready}, 32'd1);
        checkOutput("t2_d2_count", {29'b0, count}, 32'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t2_d3_addr", {27'b0, wr_addr}, 32'd3);
        checkOutput("t2_d3_count", {29'b0, count}, 32'd3);
        tick();
        checkOutput("t2_d4_addr", {27'b0, wr_addr}, 32'd4);
        checkOutput("t2_d4_data", wr_data, 32'd4);
        tick();
        checkOutput("t2_d5_wren", {31'b0, wr_en}, 32'd1);
        checkOutput("t2_d5_addr", {27'b0, wr_addr}, 32'd9);
        checkOutput("t2_d5_data", wr_data, 32'h99);
        tick();
        checkOutput("t2_empty", {31'b0, empty}, 32'd1);

        // Forwarding picks the youngest match; offered result is not forwarded
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h22, 1'b1);
        tick();
        rd_addr1 = 5'd3; rd_addr2 = 5'd7;
        rf_data1 = 32'h1234; rf_data2 = 32'h77;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t3_fwd1", fwd_data1, 32'h22);
        checkOutput("t3_fwd2", fwd_data2, 32'h77);
        applyStimulus(1'b1, 5'd7, 32'hAB, 1'b1);
        checkOutput("t3_offer_not_fwd", fwd_data2, 32'h77);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t3_drain_data", wr_data, 32'h11);
        tick();
        checkOutput("t3_fwd1_one_left", fwd_data1, 32'h22);
        checkOutput("t3_drain_data2", wr_data, 32'h22);
        tick();
        checkOutput("t3_fwd1_rf", fwd_data1, 32'h1234);

        // r0 destination is accepted but never queued, and reads of r0 are zero
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0);
        checkOutput("t4_ready", {31'b0, res_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t4_count", {29'b0, count}, 32'd0);
        checkOutput("t4_wren", {31'b0, wr_en}, 32'd0);
        rd_addr1 = 5'd0; rf_data1 = 32'h5;
        #1;
        checkOutput("t4_fwd_r0", fwd_data1, 32'h0);

        // Steady push+pop at count 2 across pointer wrap
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd11, 32'hA1, 1'b1);
        tick();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 5'(12 + k), 32'(32'hA2 + k), 1'b0);
            checkOutput("t5_wren", {31'b0, wr_en}, 32'd1);
            checkOutput("t5_addr", {27'b0, wr_addr}, 32'(10 + k));
            checkOutput("t5_data", wr_data, 32'(32'hA0 + k));
            checkOutput("t5_count", {29'b0, count}, 32'd2);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t5_tail1_addr", {27'b0, wr_addr}, 32'd16);
        tick();
        checkOutput("t5_tail2_addr", {27'b0, wr_addr}, 32'd17);
        checkOutput("t5_tail2_data", wr_data, 32'hA7);
        tick();
        checkOutput("t5_empty", {31'b0, empty}, 32'd1);

        // Mid-operation reset discards pending entries
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 5'(20 + k), 32'(32'hC0 + k), 1'b1);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("t6_count_pre", {29'b0, count}, 32'd3);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd23, 32'hC3, 1'b0);
        checkOutput("t6_rst_ready", {31'b0, res_ready}, 32'd0);
        checkOutput("t6_rst_wren", {31'b0, wr_en}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("t6_count", {29'b0, count}, 32'd0);
        checkOutput("t6_empty", {31'b0, empty}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t6_no_write", {31'b0, wr_en}, 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
